ifetch_prefetch_queue: RTL and testbench

Instruction fetch front end between instruction memory and the pipeline's IF stage. It issues sequential word fetches to a variable-latency instruction memory through a req/ack handshake. Returned words are buffered with their PCs in a small FIFO and presented downstream through a valid/ready handshake. A branch/jump redirect flushes the queue and restarts fetching at a new PC, discarding any in-flight response.

---
 rtl/ifetch_prefetch_queue.sv | 170 +++++++++++++++++
 tb/tb_ifetch_prefetch_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_queue.sv
// Instruction fetch prefetch queue: sequential word fetcher with a small PC/instruction FIFO.
// Optional combinational bypass of an ack straight to the outputs when the queue is empty is
// enabled by defining IFQ_BYPASS_EN; the default build is fully registered.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_data,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [CntW-1:0]   count_q, next_count;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];

  logic              ack_ok;
  logic              fifo_empty;
  logic              byp_valid;
  logic              byp_take;
  logic              push;
  logic              pop;
  logic              room;

  // Handshake qualification, push/pop decisions and the room check shared by FSM and FIFO
  always_comb begin
    fifo_empty = (count_q == '0);
    // An ack only counts while a live (non-discarded) request is outstanding
    ack_ok     = (state_q == StWait) && imem_ack && !redirect;
`ifdef IFQ_BYPASS_EN
    byp_valid  = fifo_empty && ack_ok;
    byp_take   = byp_valid && inst_ready;
`else
    byp_valid  = 1'b0;
    byp_take   = 1'b0;
`endif
    // A bypassed word consumed in its ack cycle never enters the FIFO
    push       = ack_ok && !byp_take;
    // Redirect wins over a pop even if the head is being accepted
    pop        = !fifo_empty && inst_ready && !redirect;
    next_count = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    room       = (next_count < DepthC);
  end

  // Fetch FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state, fetch PC and request address
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end
    case (state_q)
      StIdle: begin
        if (!redirect && room) begin
          state_d    = StWait;
          req_addr_d = fetch_pc_q;
        end
      end
      StWait: begin
        if (redirect) begin
          // Same-cycle ack is simply dropped; otherwise wait out the stale response
          state_d = imem_ack ? StIdle : StDrop;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (room) begin
            req_addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StDrop: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch PC and held request address
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // FIFO pointers and occupancy; redirect clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q <= next_count;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; cleared on reset so the outputs read zero out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[PtrW'(i)]   <= '0;
        inst_mem[PtrW'(i)] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= imem_data;
    end
  end

  // Memory-side and downstream outputs
  always_comb begin
    imem_req   = (state_q != StIdle);
    imem_addr  = req_addr_q;
    level      = count_q;
    inst_valid = !fifo_empty || byp_valid;
    inst_out   = inst_mem[rd_ptr_q];
    pc_out     = pc_mem[rd_ptr_q];
    if (byp_valid) begin
      inst_out = imem_data;
      pc_out   = fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Scoreboard bench for ifetch_prefetch_queue: a latency-programmable memory model, directed
// stimulus pushing expected {pc, inst} pairs, and a monitor that checks every accepted output.
module tb_ifetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [$clog2(DEPTH):0] level;

  int unsigned lat;
  int unsigned wait_cnt;
  logic        ready_en;
  logic [63:0] exp_q [$];
  int          pass_cnt;
  int          total_cnt;
  int          ack_cnt;
  int          ack_base;

  ifetch_prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack arrives after 'lat' idle cycles of an outstanding request
  initial wait_cnt = 0;
  always @(posedge clk) wait_cnt <= (!imem_req || imem_ack) ? 0 : wait_cnt + 1;
  assign imem_ack  = imem_req && (wait_cnt == lat);
  assign imem_data = imem_addr ^ KEY;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: every accepted head entry must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst && imem_req && imem_ack) ack_cnt++;
      if (rst && inst_valid && inst_ready && !redirect) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_out: got pc %h inst %h want nothing", pc_out, inst_out);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({pc_out, inst_out} === e) pass_cnt++;
          else $display("FAIL out_entry: got pc %h inst %h want pc %h inst %h",
                        pc_out, inst_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, pc ^ KEY});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inst_ready = ready_en && (exp_q.size() != 0);
  endtask

  task automatic set_ready(input logic en);
    ready_en   = en;
    inst_ready = en && (exp_q.size() != 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    set_ready(1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0; total_cnt = 0; ack_cnt = 0; ack_base = 0;
    lat = 0; ready_en = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_req",   32'(imem_req),   0);
    check("rst_addr",  imem_addr,       0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_level", 32'(level),      0);
    check("rst_inst",  inst_out,        0);
    check("rst_pc",    pc_out,          0);

    // Zero-wait streaming with inst_ready high: one entry per cycle
    tick(); tick();
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    set_ready(1'b1);
    rst = 1'b1;
    tick();
    check("first_req",  32'(imem_req), 1);
    check("first_addr", imem_addr,     0);
    repeat (6) tick();
    check("stream_rate", exp_q.size(), 1);
    tick();
    check("stream_done", exp_q.size(), 0);
    check("stream_level", 32'(level),  1);
    check("stream_addr",  imem_addr,   32'd28);

    // Reset in the middle of an outstanding request
    rst = 1'b0;
    #1;
    check("midrst_req",   32'(imem_req), 0);
    check("midrst_level", 32'(level),    0);
    set_ready(1'b0);
    rst = 1'b1;
    tick();
    check("postrst_addr", imem_addr,     0);
    check("postrst_req",  32'(imem_req), 1);

    // Fill with inst_ready low, then one pop reissues the request
    lat = 0;
    do_reset();
    ack_base = ack_cnt;
    repeat (5) tick();
    check("full_req",   32'(imem_req), 0);
    check("full_level", 32'(level),    4);
    tick(); tick();
    check("full_hold_level", 32'(level), 4);
    check("full_ack_cnt", ack_cnt - ack_base, 4);
    expect_pc(32'h0);
    set_ready(1'b1);
    tick();
    check("refill_req",  32'(imem_req), 1);
    check("refill_addr", imem_addr,     32'd16);
    check("pop_done",    exp_q.size(),  0);

    // Redirect while waiting on a slow memory: stale word is discarded
    lat = 3;
    do_reset();
    expect_pc(32'h100);
    expect_pc(32'h104);
    set_ready(1'b1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("drop_req",   32'(imem_req),   1);
    check("drop_addr",  imem_addr,       0);
    check("drop_valid", 32'(inst_valid), 0);
    repeat (3) tick();
    check("drop_idle",  32'(imem_req), 0);
    check("drop_level", 32'(level),    0);
    tick();
    check("redir_addr", imem_addr, 32'h100);
    drain("redir_drain", 60);

    // Redirect coinciding with an ack and a pop at level 2
    lat = 0;
    do_reset();
    repeat (3) tick();
    check("pre_redir_level", 32'(level), 2);
    redirect = 1'b1; redirect_pc = 32'h200;
    inst_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("redir_level", 32'(level),      0);
    check("redir_valid", 32'(inst_valid), 0);
    tick();
    check("redir200_addr", imem_addr, 32'h200);
    expect_pc(32'h200);
    set_ready(1'b1);
    drain("redir200_drain", 20);

    // fetch_pc wraps past the top of the address space
    set_ready(1'b0);
    do_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    set_ready(1'b1);
    tick();
    check("wrap_addr_zero", imem_addr, 32'h0);
    drain("wrap_drain", 20);

`ifdef IFQ_BYPASS_EN
    // Empty queue: the acked word is valid in its ack cycle
    set_ready(1'b0);
    do_reset();
    tick();
    check("bypass_valid", 32'(inst_valid), 1);
    check("bypass_pc",    pc_out,          0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
